reg_write_ctrl: RTL and testbench

REG_WRITE_CTRL -- requirements
Module: reg_write_ctrl

---
 rtl/reg_write_pkg.sv | 14 +
 rtl/reg_write_chan.sv | 122 ++++++++++++
 rtl/reg_write_ctrl.sv | 44 ++++
 tb/tb_reg_write_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_write_pkg.sv
// Shared select codes and channel state encoding for the register-write controller.
package reg_write_pkg;

    localparam int unsigned SEL_NOP = 32'd0;
    localparam int unsigned SEL_TP1 = 32'd1;
    localparam int unsigned SEL_TP2 = 32'd2;
    localparam int unsigned SEL_AC  = 32'd3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } chan_state_e;

endpackage

// File: rtl/reg_write_chan.sv
// One core channel: accepts a select/length request and holds a single
// registered load enable for the requested number of cycles.
module reg_write_chan
    import reg_write_pkg::*;
#(
    parameter int NUM_REGS = 3,
    parameter int SEL_W    = 4,
    parameter int LEN_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [SEL_W-1:0]    req_sel,
    input  logic [LEN_W-1:0]    req_len,
    input  logic                flush,
    input  logic                err_clr,
    output logic [NUM_REGS-1:0] ld_en,
    output logic                busy,
    output logic                err
);

    chan_state_e         state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REGS-1:0] ld_en_q, ld_en_d;
    logic                err_q, err_d;
    logic                live_q, live_d;

    logic                ready_s;
    logic                accept_s;
    logic                sel_legal_s;
    logic                sel_illegal_s;
    logic [LEN_W-1:0]    len_eff_s;

    // Request handshake decode and effective length (zero length means one cycle).
    always_comb begin
        ready_s       = live_q && !flush &&
                        ((state_q == ST_IDLE) ||
                         ((state_q == ST_BURST) && (cnt_q == LEN_W'(1))));
        accept_s      = ready_s && req_valid;
        sel_legal_s   = (req_sel != SEL_W'(SEL_NOP)) && (req_sel <= SEL_W'(NUM_REGS));
        sel_illegal_s = (req_sel > SEL_W'(NUM_REGS));
        if (req_len == LEN_W'(0)) begin
            len_eff_s = LEN_W'(1);
        end else begin
            len_eff_s = req_len;
        end
    end

    // Next-state, burst counter, enable row and sticky error.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ld_en_d = ld_en_q;
        live_d  = 1'b1;

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = LEN_W'(0);
            ld_en_d = NUM_REGS'(0);
        end else if (accept_s && sel_legal_s) begin
            // A legal accept in the last burst cycle lands here too, so chaining has no gap.
            ld_en_d = NUM_REGS'(1) << (req_sel - SEL_W'(1));
            if (len_eff_s > LEN_W'(1)) begin
                state_d = ST_BURST;
                cnt_d   = len_eff_s;
            end else begin
                state_d = ST_IDLE;
                cnt_d   = LEN_W'(0);
            end
        end else begin
            case (state_q)
                ST_BURST: begin
                    if (cnt_q > LEN_W'(1)) begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = LEN_W'(0);
                        ld_en_d = NUM_REGS'(0);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = LEN_W'(0);
                    ld_en_d = NUM_REGS'(0);
                end
            endcase
        end

        // A new illegal accept wins over a simultaneous clear.
        if (accept_s && sel_illegal_s) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Channel state registers; live_q keeps the release edge from accepting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= LEN_W'(0);
            ld_en_q <= NUM_REGS'(0);
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ld_en_q <= ld_en_d;
            err_q   <= err_d;
            live_q  <= live_d;
        end
    end

    assign req_ready = ready_s;
    assign ld_en     = ld_en_q;
    assign busy      = (state_q == ST_BURST);
    assign err       = err_q;

endmodule

// File: rtl/reg_write_ctrl.sv
// Multi-core register-write controller: NUM_CORES independent channels
// sharing only the clock and reset.
module reg_write_ctrl
    import reg_write_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int NUM_REGS  = 3,
    parameter int SEL_W     = 4,
    parameter int LEN_W     = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CORES-1:0]          req_valid,
    output logic [NUM_CORES-1:0]          req_ready,
    input  logic [NUM_CORES*SEL_W-1:0]    req_sel,
    input  logic [NUM_CORES*LEN_W-1:0]    req_len,
    input  logic [NUM_CORES-1:0]          flush,
    input  logic [NUM_CORES-1:0]          err_clr,
    output logic [NUM_CORES*NUM_REGS-1:0] ld_en,
    output logic [NUM_CORES-1:0]          busy,
    output logic [NUM_CORES-1:0]          err
);

    for (genvar c = 0; c < NUM_CORES; c++) begin : g_chan
        reg_write_chan #(
            .NUM_REGS (NUM_REGS),
            .SEL_W    (SEL_W),
            .LEN_W    (LEN_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[c]),
            .req_ready (req_ready[c]),
            .req_sel   (req_sel[c*SEL_W +: SEL_W]),
            .req_len   (req_len[c*LEN_W +: LEN_W]),
            .flush     (flush[c]),
            .err_clr   (err_clr[c]),
            .ld_en     (ld_en[c*NUM_REGS +: NUM_REGS]),
            .busy      (busy[c]),
            .err       (err[c])
        );
    end

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Scoreboard bench for reg_write_ctrl: a per-core reference model pushes the
// expected outputs for each cycle, compared after the following clock edge.
module tb_reg_write_ctrl;

    localparam int NC = 4;
    localparam int NR = 3;
    localparam int SW = 4;
    localparam int LW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NC-1:0]     req_valid, req_ready, flush, err_clr, busy, err;
    logic [NC*SW-1:0]  req_sel;
    logic [NC*LW-1:0]  req_len;
    logic [NC*NR-1:0]  ld_en;

    typedef struct packed {
        logic [NC*NR-1:0] ld;
        logic [NC-1:0]    bsy;
        logic [NC-1:0]    er;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: remaining enable cycles per core, active register, long-burst flag.
    int   m_left[NC];
    int   m_reg[NC];
    bit   m_long[NC];
    bit   m_err[NC];
    bit   m_live;

    always #5 clk = ~clk;

    reg_write_ctrl #(.NUM_CORES(NC), .NUM_REGS(NR), .SEL_W(SW), .LEN_W(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sel   (req_sel),
        .req_len   (req_len),
        .flush     (flush),
        .err_clr   (err_clr),
        .ld_en     (ld_en),
        .busy      (busy),
        .err       (err)
    );

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_left[c] = 0;
            m_reg[c]  = 1;
            m_long[c] = 1'b0;
            m_err[c]  = 1'b0;
        end
        m_live = 1'b0;
    endtask

    task automatic set_req(input int c, input int sel, input int len);
        req_valid[c]           = 1'b1;
        req_sel[c*SW +: SW]    = SW'(sel);
        req_len[c*LW +: LW]    = LW'(len);
    endtask

    // One clock: check ready, advance the model, compare outputs after the edge.
    task automatic step();
        logic [NC-1:0] rdy;
        logic [NC-1:0] acc;
        exp_t          e;
        int            sel;
        int            len;
        @(negedge clk);
        for (int c = 0; c < NC; c++) begin
            rdy[c] = m_live && !flush[c] && (m_left[c] <= 1);
        end
        chk_val("req_ready", 32'(req_ready), 32'(rdy));
        e = '0;
        for (int c = 0; c < NC; c++) begin
            sel = int'(req_sel[c*SW +: SW]);
            len = int'(req_len[c*LW +: LW]);
            if (len == 0) len = 1;
            acc[c] = rdy[c] && req_valid[c];
            if (flush[c]) begin
                m_left[c] = 0;
                m_long[c] = 1'b0;
            end else if (acc[c] && sel >= 1 && sel <= NR) begin
                m_reg[c]  = sel;
                m_left[c] = len;
                m_long[c] = (len > 1);
            end else begin
                if (m_left[c] > 0) m_left[c]--;
                if (m_left[c] == 0) m_long[c] = 1'b0;
            end
            if (acc[c] && sel > NR) m_err[c] = 1'b1;
            else if (err_clr[c])    m_err[c] = 1'b0;
            e.bsy[c] = m_long[c] && (m_left[c] > 0);
            e.er[c]  = m_err[c];
            if (m_left[c] > 0) e.ld[c*NR + m_reg[c] - 1] = 1'b1;
        end
        m_live = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk_val("ld_en", 32'(ld_en), 32'(e.ld));
        chk_val("busy",  32'(busy),  32'(e.bsy));
        chk_val("err",   32'(err),   32'(e.er));
        for (int c = 0; c < NC; c++) begin
            if (acc[c]) req_valid[c] = 1'b0;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk_val({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk_val({tag, "_ld_en"}, 32'(ld_en),     32'd0);
        chk_val({tag, "_busy"},  32'(busy),      32'd0);
        chk_val({tag, "_err"},   32'(err),       32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_sel   = '0;
        req_len   = '0;
        flush     = '0;
        err_clr   = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("in_reset");
        rst_n = 1'b1;

        // Request already valid on the first edge after release must wait one cycle.
        set_req(0, 2, 1);
        steps(4);

        // Core1: long burst, follow-up held valid until the last burst cycle.
        set_req(1, 3, 4);
        step();
        set_req(1, 1, 2);
        steps(7);

        // Core2: illegal select, clear, clear racing a new illegal accept, then NOP.
        set_req(2, 9, 1);
        steps(2);
        err_clr[2] = 1'b1;
        step();
        err_clr[2] = 1'b0;
        step();
        set_req(2, 9, 1);
        step();
        set_req(2, 9, 1);
        err_clr[2] = 1'b1;
        step();
        err_clr[2] = 1'b0;
        set_req(2, 0, 5);
        steps(3);

        // Core3: flush in the third burst cycle with a competing request, sel changed mid-burst.
        set_req(3, 3, 8);
        step();
        req_sel[3*SW +: SW] = 4'd1;
        req_len[3*LW +: LW] = 4'd2;
        steps(2);
        flush[3] = 1'b1;
        set_req(3, 1, 2);
        step();
        flush[3]     = 1'b0;
        req_valid[3] = 1'b0;
        steps(2);

        // Zero length behaves as one cycle.
        set_req(0, 1, 0);
        steps(3);

        // All cores at once with differing lengths.
        set_req(0, 1, 2);
        set_req(1, 2, 3);
        set_req(2, 3, 5);
        set_req(3, 1, 1);
        steps(7);

        // Randomised traffic across all cores.
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < NC; c++) begin
                req_valid[c]        = 1'($urandom_range(0, 1));
                req_sel[c*SW +: SW] = SW'($urandom_range(0, 5));
                req_len[c*LW +: LW] = LW'($urandom_range(0, 6));
                flush[c]            = ($urandom_range(0, 15) == 0);
                err_clr[c]          = ($urandom_range(0, 7) == 0);
            end
            step();
        end
        req_valid = '0;
        flush     = '0;
        err_clr   = '0;
        set_req(2, 12, 1);
        step();

        // Asynchronous reset in the middle of a core0 burst.
        set_req(0, 1, 6);
        steps(2);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        model_reset();
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_req(0, 2, 1);
        steps(4);

        chk_val("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
